// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: turns framed UART commands into single 32-bit memory
// reads/writes and streams the response back through the UART transmitter.
module uart_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  input  logic        rx_error,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy,
  output logic        active
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RESP_OK   = 8'h4B;
  localparam logic [7:0] RESP_UNK  = 8'h3F;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_GET_ADDR    = 4'd1,
    ST_GET_DATA    = 4'd2,
    ST_BUS_WR      = 4'd3,
    ST_BUS_WR_WAIT = 4'd4,
    ST_BUS_RD      = 4'd5,
    ST_BUS_RD_WAIT = 4'd6,
    ST_SEND        = 4'd7,
    ST_SEND_WAIT   = 4'd8
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_is_write, w_is_write_nxt;
  logic [1:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [31:0] r_resp, w_resp_nxt;
  logic [2:0]  r_resp_left, w_resp_left_nxt;
  logic        r_seen_busy, w_seen_busy_nxt;
  logic [31:0] r_timer, w_timer_nxt;
  logic        r_rx_ack, w_rx_ack_nxt;
  logic        r_tx_wr, w_tx_wr_nxt;
  logic [7:0]  r_tx_data, w_tx_data_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]  r_mem_wmask, w_mem_wmask_nxt;
  logic        r_mem_rstrb, w_mem_rstrb_nxt;
  logic        r_active;

  // The receiver needs one cycle to clear after an ack, so nothing is taken while rx_ack is high.
  logic        w_take_err, w_take_byte, w_timed_out;
  logic [31:0] w_addr_shift, w_data_shift;

  assign w_take_err   = rx_error & ~r_rx_ack;
  assign w_take_byte  = rx_avail & ~rx_error & ~r_rx_ack;
  assign w_timed_out  = (TIMEOUT_CYCLES != 32'd0) && (r_timer == TIMEOUT_CYCLES);
  assign w_addr_shift = {r_addr[23:0], rx_data};
  assign w_data_shift = {r_data[23:0], rx_data};

  // Next-state and next-output logic for the frame / bus / response sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_is_write_nxt   = r_is_write;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_addr_nxt       = r_addr;
    w_data_nxt       = r_data;
    w_resp_nxt       = r_resp;
    w_resp_left_nxt  = r_resp_left;
    w_seen_busy_nxt  = r_seen_busy;
    w_timer_nxt      = r_timer;
    w_rx_ack_nxt     = 1'b0;
    w_tx_wr_nxt      = 1'b0;
    w_tx_data_nxt    = r_tx_data;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_wmask_nxt  = 4'h0;
    w_mem_rstrb_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_take_err) begin
          w_rx_ack_nxt = 1'b1;
        end else if (w_take_byte) begin
          w_rx_ack_nxt   = 1'b1;
          w_byte_cnt_nxt = 2'd0;
          w_timer_nxt    = 32'd0;
          if (rx_data == CMD_WRITE) begin
            w_is_write_nxt = 1'b1;
            w_state_nxt    = ST_GET_ADDR;
          end else if (rx_data == CMD_READ) begin
            w_is_write_nxt = 1'b0;
            w_state_nxt    = ST_GET_ADDR;
          end else begin
            w_resp_nxt      = {RESP_UNK, 24'h000000};
            w_resp_left_nxt = 3'd1;
            w_state_nxt     = ST_SEND;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GET_ADDR: begin
        if (w_take_err) begin
          w_rx_ack_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (w_take_byte) begin
          w_rx_ack_nxt   = 1'b1;
          w_timer_nxt    = 32'd0;
          w_addr_nxt     = w_addr_shift;
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            if (r_is_write) begin
              w_state_nxt = ST_GET_DATA;
            end else begin
              w_mem_addr_nxt = {w_addr_shift[31:2], 2'b00};
              w_state_nxt    = ST_BUS_RD;
            end
          end else begin
            w_state_nxt = ST_GET_ADDR;
          end
        end else if (w_timed_out) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
      end
      ST_GET_DATA: begin
        if (w_take_err) begin
          w_rx_ack_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (w_take_byte) begin
          w_rx_ack_nxt   = 1'b1;
          w_timer_nxt    = 32'd0;
          w_data_nxt     = w_data_shift;
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_mem_addr_nxt  = {r_addr[31:2], 2'b00};
            w_mem_wdata_nxt = w_data_shift;
            w_state_nxt     = ST_BUS_WR;
          end else begin
            w_state_nxt = ST_GET_DATA;
          end
        end else if (w_timed_out) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
      end
      ST_BUS_WR: begin
        w_mem_wmask_nxt = 4'hF;
        w_state_nxt     = ST_BUS_WR_WAIT;
      end
      ST_BUS_WR_WAIT: begin
        if (!mem_wbusy) begin
          w_resp_nxt      = {RESP_OK, 24'h000000};
          w_resp_left_nxt = 3'd1;
          w_state_nxt     = ST_SEND;
        end else begin
          w_state_nxt = ST_BUS_WR_WAIT;
        end
      end
      ST_BUS_RD: begin
        w_mem_rstrb_nxt = 1'b1;
        w_state_nxt     = ST_BUS_RD_WAIT;
      end
      ST_BUS_RD_WAIT: begin
        if (!mem_rbusy) begin
          w_resp_nxt      = mem_rdata;
          w_resp_left_nxt = 3'd4;
          w_state_nxt     = ST_SEND;
        end else begin
          w_state_nxt = ST_BUS_RD_WAIT;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          w_tx_data_nxt   = r_resp[31:24];
          w_tx_wr_nxt     = 1'b1;
          w_resp_nxt      = {r_resp[23:0], 8'h00};
          w_resp_left_nxt = r_resp_left - 3'd1;
          w_seen_busy_nxt = 1'b0;
          w_state_nxt     = ST_SEND_WAIT;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND_WAIT: begin
        // tx_busy may not yet reflect our own tx_wr pulse, so that cycle is skipped.
        if (r_tx_wr) begin
          w_state_nxt = ST_SEND_WAIT;
        end else if (!r_seen_busy) begin
          w_seen_busy_nxt = tx_busy;
        end else if (!tx_busy) begin
          w_state_nxt = (r_resp_left != 3'd0) ? ST_SEND : ST_IDLE;
        end else begin
          w_state_nxt = ST_SEND_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_is_write  <= 1'b0;
      r_byte_cnt  <= 2'd0;
      r_addr      <= 32'd0;
      r_data      <= 32'd0;
      r_resp      <= 32'd0;
      r_resp_left <= 3'd0;
      r_seen_busy <= 1'b0;
      r_timer     <= 32'd0;
      r_rx_ack    <= 1'b0;
      r_tx_wr     <= 1'b0;
      r_tx_data   <= 8'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wmask <= 4'h0;
      r_mem_rstrb <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_is_write  <= w_is_write_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_resp      <= w_resp_nxt;
      r_resp_left <= w_resp_left_nxt;
      r_seen_busy <= w_seen_busy_nxt;
      r_timer     <= w_timer_nxt;
      r_rx_ack    <= w_rx_ack_nxt;
      r_tx_wr     <= w_tx_wr_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_wmask <= w_mem_wmask_nxt;
      r_mem_rstrb <= w_mem_rstrb_nxt;
      r_active    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign rx_ack    = r_rx_ack;
  assign tx_data   = r_tx_data;
  assign tx_wr     = r_tx_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;
  assign mem_rstrb = r_mem_rstrb;
  assign active    = r_active;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed scenarios for the UART debug bus bridge.
module tb_uart_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_avail;
  logic        rx_error;
  logic        rx_ack;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;
  logic        active;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          ack_cnt = 0;
  int          wmask_cnt = 0;
  int          rstrb_cnt = 0;
  int          busy_viol = 0;
  logic [31:0] cap_addr = 32'd0;
  logic [31:0] cap_wdata = 32'd0;
  logic [31:0] rd_addr = 32'd0;
  logic [7:0]  tx_q[$];
  logic        busy_at_edge = 1'b0;
  logic        wbusy_hold = 1'b0;
  logic [31:0] rd_value = 32'h12345678;
  int          wb_cnt;
  int          rb_cnt;

  always #5 clk = ~clk;

  uart_bus_bridge #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy),
    .mem_wbusy(mem_wbusy), .active(active)
  );

  // Transmitter busy level as seen by the DUT at each rising edge.
  always @(posedge clk) busy_at_edge <= tx_busy;

  // Observe strobes and transmitted bytes between edges.
  always @(negedge clk) begin
    if (rx_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    if (mem_wmask === 4'hF) begin
      wmask_cnt <= wmask_cnt + 1;
      cap_addr  <= mem_addr;
      cap_wdata <= mem_wdata;
    end
    if (mem_rstrb === 1'b1) begin
      rstrb_cnt <= rstrb_cnt + 1;
      rd_addr   <= mem_addr;
    end
    if (tx_wr === 1'b1) begin
      tx_q.push_back(tx_data);
      if (busy_at_edge !== 1'b0) busy_viol <= busy_viol + 1;
    end
  end

  // Transmitter model: busy for a few cycles after each send pulse.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_wr === 1'b1) begin
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // Memory model: write busy 2 cycles (or held), read busy 3 cycles with junk data meanwhile.
  initial begin
    mem_wbusy = 1'b0; mem_rbusy = 1'b0; mem_rdata = 32'd0; wb_cnt = 0; rb_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_wmask === 4'hF) wb_cnt = 2; else if (wb_cnt > 0) wb_cnt--;
      mem_wbusy = wbusy_hold || (wb_cnt > 0);
      if (mem_rstrb === 1'b1) rb_cnt = 3; else if (rb_cnt > 0) rb_cnt--;
      mem_rbusy = (rb_cnt > 0);
      mem_rdata = (rb_cnt > 0) ? 32'hBAD0BAD0 : rd_value;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic err);
    int n;
    @(negedge clk);
    rx_data = b; rx_avail = 1'b1; rx_error = err;
    n = 0;
    while (rx_ack !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (rx_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_ack_wait: byte %02h rx_ack=%b after 50 cycles, required 1", b, rx_ack);
    end
    @(posedge clk);
    #1;
    rx_avail = 1'b0; rx_error = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (active !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: active=%b after %0d cycles, required 0", active, maxc);
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_data = 8'd0; rx_avail = 1'b0; rx_error = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_ack !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ack: got %b, required 0", rx_ack); end
    n_cmp++; if (tx_wr !== 1'b0) begin n_fail++; $display("FAIL reset_tx_wr: got %b, required 0", tx_wr); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h, required 0", mem_wdata); end
    n_cmp++; if (mem_wmask !== 4'h0) begin n_fail++; $display("FAIL reset_mem_wmask: got %h, required 0", mem_wmask); end
    n_cmp++; if (mem_rstrb !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rstrb: got %b, required 0", mem_rstrb); end
    n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b, required 0", active); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int a0, w0, r0, t0, v0;
    logic [7:0] frame [9];
    frame = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    a0 = ack_cnt; w0 = wmask_cnt; r0 = rstrb_cnt; t0 = tx_q.size(); v0 = busy_viol;
    for (int i = 0; i < 9; i++) send_byte(frame[i], 1'b0);
    wait_idle(200);
    n_cmp++; if (wmask_cnt - w0 != 1) begin n_fail++; $display("FAIL wr_wmask_pulses: got %0d, required 1", wmask_cnt - w0); end
    n_cmp++; if (cap_addr !== 32'h00001004) begin n_fail++; $display("FAIL wr_addr: got %h, required 00001004", cap_addr); end
    n_cmp++; if (cap_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_wdata: got %h, required deadbeef", cap_wdata); end
    n_cmp++; if (ack_cnt - a0 != 9) begin n_fail++; $display("FAIL wr_acks: got %0d, required 9", ack_cnt - a0); end
    n_cmp++; if (rstrb_cnt - r0 != 0) begin n_fail++; $display("FAIL wr_no_read: got %0d read strobes, required 0", rstrb_cnt - r0); end
    n_cmp++; if (tx_q.size() - t0 != 1) begin n_fail++; $display("FAIL wr_tx_count: got %0d, required 1", tx_q.size() - t0); end
    n_cmp++; if (tx_q.size() > t0 && tx_q[t0] !== 8'h4B) begin n_fail++; $display("FAIL wr_tx_byte: got %h, required 4b", tx_q[t0]); end
    n_cmp++; if (busy_viol != v0) begin n_fail++; $display("FAIL wr_tx_busy: got %0d sends while busy, required 0", busy_viol - v0); end
  endtask

  task automatic read_frame(input logic [31:0] addr_in, input logic [31:0] addr_exp,
                            input logic [31:0] data, input int tag);
    int a0, w0, r0, t0, v0;
    logic [7:0] got;
    logic [7:0] frame [5];
    logic [7:0] exp_b [4];
    frame = '{8'h52, addr_in[31:24], addr_in[23:16], addr_in[15:8], addr_in[7:0]};
    exp_b = '{data[31:24], data[23:16], data[15:8], data[7:0]};
    rd_value = data;
    a0 = ack_cnt; w0 = wmask_cnt; r0 = rstrb_cnt; t0 = tx_q.size(); v0 = busy_viol;
    for (int i = 0; i < 5; i++) send_byte(frame[i], 1'b0);
    wait_idle(300);
    n_cmp++; if (rstrb_cnt - r0 != 1) begin n_fail++; $display("FAIL rd%0d_strobes: got %0d, required 1", tag, rstrb_cnt - r0); end
    n_cmp++; if (rd_addr !== addr_exp) begin n_fail++; $display("FAIL rd%0d_addr: got %h, required %h", tag, rd_addr, addr_exp); end
    n_cmp++; if (wmask_cnt - w0 != 0) begin n_fail++; $display("FAIL rd%0d_no_write: got %0d, required 0", tag, wmask_cnt - w0); end
    n_cmp++; if (ack_cnt - a0 != 5) begin n_fail++; $display("FAIL rd%0d_acks: got %0d, required 5", tag, ack_cnt - a0); end
    n_cmp++; if (tx_q.size() - t0 != 4) begin n_fail++; $display("FAIL rd%0d_tx_count: got %0d, required 4", tag, tx_q.size() - t0); end
    for (int i = 0; i < 4; i++) begin
      got = (tx_q.size() > t0 + i) ? tx_q[t0 + i] : 8'hxx;
      n_cmp++;
      if (got !== exp_b[i]) begin n_fail++; $display("FAIL rd%0d_tx_byte%0d: got %h, required %h", tag, i, got, exp_b[i]); end
    end
    n_cmp++; if (busy_viol != v0) begin n_fail++; $display("FAIL rd%0d_tx_busy: got %0d sends while busy, required 0", tag, busy_viol - v0); end
  endtask

  task automatic test_read();
    read_frame(32'h00002003, 32'h00002000, 32'h12345678, 0);
  endtask

  task automatic test_unknown();
    int a0, w0, r0, t0;
    a0 = ack_cnt; w0 = wmask_cnt; r0 = rstrb_cnt; t0 = tx_q.size();
    send_byte(8'h41, 1'b0);
    wait_idle(100);
    n_cmp++; if (tx_q.size() - t0 != 1) begin n_fail++; $display("FAIL unk_tx_count: got %0d, required 1", tx_q.size() - t0); end
    n_cmp++; if (tx_q.size() > t0 && tx_q[t0] !== 8'h3F) begin n_fail++; $display("FAIL unk_tx_byte: got %h, required 3f", tx_q[t0]); end
    n_cmp++; if ((wmask_cnt - w0) + (rstrb_cnt - r0) != 0) begin n_fail++; $display("FAIL unk_bus: got %0d bus strobes, required 0", (wmask_cnt - w0) + (rstrb_cnt - r0)); end
    n_cmp++; if (ack_cnt - a0 != 1) begin n_fail++; $display("FAIL unk_acks: got %0d, required 1", ack_cnt - a0); end
    n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL unk_active: got %b, required 0", active); end
  endtask

  task automatic test_timeout();
    int w0, r0, t0;
    w0 = wmask_cnt; r0 = rstrb_cnt; t0 = tx_q.size();
    send_byte(8'h57, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (90) @(negedge clk);
    n_cmp++; if (active !== 1'b1) begin n_fail++; $display("FAIL to_early: active=%b at 90 idle cycles, required 1", active); end
    repeat (20) @(negedge clk);
    n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL to_abort: active=%b at 110 idle cycles, required 0", active); end
    n_cmp++; if (tx_q.size() - t0 != 0) begin n_fail++; $display("FAIL to_no_tx: got %0d bytes, required 0", tx_q.size() - t0); end
    n_cmp++; if ((wmask_cnt - w0) + (rstrb_cnt - r0) != 0) begin n_fail++; $display("FAIL to_no_bus: got %0d bus strobes, required 0", (wmask_cnt - w0) + (rstrb_cnt - r0)); end
    read_frame(32'h00000040, 32'h00000040, 32'hCAFEF00D, 1);
  endtask

  task automatic test_rx_error();
    int a0, w0, r0, t0;
    a0 = ack_cnt; w0 = wmask_cnt; r0 = rstrb_cnt; t0 = tx_q.size();
    send_byte(8'h52, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h77, 1'b1);
    repeat (20) @(negedge clk);
    n_cmp++; if (ack_cnt - a0 != 4) begin n_fail++; $display("FAIL err_acks: got %0d, required 4", ack_cnt - a0); end
    n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL err_active: got %b, required 0", active); end
    n_cmp++; if (tx_q.size() - t0 != 0) begin n_fail++; $display("FAIL err_no_tx: got %0d bytes, required 0", tx_q.size() - t0); end
    n_cmp++; if ((wmask_cnt - w0) + (rstrb_cnt - r0) != 0) begin n_fail++; $display("FAIL err_no_bus: got %0d bus strobes, required 0", (wmask_cnt - w0) + (rstrb_cnt - r0)); end
  endtask

  task automatic test_reset_mid();
    int w0, t0;
    logic [7:0] frame [9];
    frame = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44};
    w0 = wmask_cnt; t0 = tx_q.size();
    wbusy_hold = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(frame[i], 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++; if (wmask_cnt - w0 != 1) begin n_fail++; $display("FAIL rm_wmask: got %0d pulses, required 1", wmask_cnt - w0); end
    n_cmp++; if (active !== 1'b1) begin n_fail++; $display("FAIL rm_active_before: got %b, required 1", active); end
    n_cmp++; if (mem_wdata !== 32'h11223344) begin n_fail++; $display("FAIL rm_wdata_held: got %h, required 11223344", mem_wdata); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL rm_active: got %b, required 0", active); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_mem_addr: got %h, required 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rm_mem_wdata: got %h, required 0", mem_wdata); end
    n_cmp++; if ({rx_ack, tx_wr, mem_rstrb, mem_wmask} !== 7'd0) begin n_fail++; $display("FAIL rm_strobes: got %b, required 0000000", {rx_ack, tx_wr, mem_rstrb, mem_wmask}); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rm_tx_data: got %h, required 00", tx_data); end
    @(negedge clk);
    reset = 1'b0;
    wbusy_hold = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++; if (tx_q.size() - t0 != 0) begin n_fail++; $display("FAIL rm_no_tx: got %0d bytes, required 0", tx_q.size() - t0); end
    n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL rm_idle_after: got %b, required 0", active); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_unknown();
    test_timeout();
    test_rx_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

- Host-debug bus master. Consumes the byte stream from the UART receiver and drives single 32-bit transactions on the CPU-side memory interface.
- Returns responses through the UART transmitter, so a PC can peek and poke SoC memory and peripherals without CPU involvement.
- Sits between the `uart` byte ports and the memory bus arbiter.

## Interface
- `TIMEOUT_CYCLES`, default 12000000: max idle clocks between bytes inside a frame before abort. 0 disables the timeout.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_avail` in 1: byte pending.
- `rx_error` in 1: framing error pending.
- `rx_ack` out 1: one-cycle pulse; consumes the pending byte or error.
- `tx_data` out 8: byte to send.
- `tx_wr` out 1: one-cycle send pulse.
- `tx_busy` in 1: transmitter busy.
- `mem_addr` out 32: word address; bits [1:0] always 0.
- `mem_wdata` out 32: write data.
- `mem_wmask` out 4: byte enables; 4'hF for one cycle per write, else 0.
- `mem_rstrb` out 1: one-cycle read strobe.
- `mem_rdata` in 32: read data.
- `mem_rbusy` in 1: read in progress.
- `mem_wbusy` in 1: write in progress.
- `active` out 1: high whenever state is not IDLE.

## Operation
- Frame formats, multi-byte fields big-endian:
  - Write: `0x57 'W'`, A3 A2 A1 A0, D3 D2 D1 D0. Response: `0x4B 'K'`.
  - Read: `0x52 'R'`, A3 A2 A1 A0. Response: D3 D2 D1 D0.
  - Any other command byte: response `0x3F '?'`, then IDLE.
- States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_WR_WAIT, BUS_RD, BUS_RD_WAIT, SEND, SEND_WAIT.
- Byte acceptance:
  - A byte is accepted in IDLE, GET_ADDR and GET_DATA at an edge where `rx_avail`=1, `rx_error`=0 and `rx_ack`=0.
  - On acceptance, `rx_ack` goes 1 for exactly one cycle.
  - `rx_avail` is ignored while `rx_ack`=1, because the receiver clears one cycle after the ack.
- Field assembly:
  - A 2-bit byte counter indexes each 4-byte field.
  - Fields shift in MSB-first: `{reg[23:0], rx_data}`.
- State transitions:
  - IDLE: 'W' or 'R' → GET_ADDR. Other byte → SEND with the '?' response.
  - GET_ADDR, 4th byte: W → GET_DATA; R → BUS_RD.
  - GET_DATA, 4th byte → BUS_WR.
  - BUS_WR: `mem_wmask`=4'hF for one cycle, with `mem_addr`/`mem_wdata` valid → BUS_WR_WAIT.
  - BUS_WR_WAIT: when `mem_wbusy`=0 → SEND with 'K'.
  - BUS_RD: `mem_rstrb`=1 for one cycle → BUS_RD_WAIT.
  - BUS_RD_WAIT: on the first cycle with `mem_rbusy`=0, capture `mem_rdata` → SEND with 4 bytes (D3 first).
  - SEND: when `tx_busy`=0, load `tx_data` and pulse `tx_wr` → SEND_WAIT.
  - SEND_WAIT: ignore `tx_busy` in the cycle `tx_wr`=1. Afterwards, wait for `tx_busy`=1 then 0. More bytes → SEND; else → IDLE.
- `mem_addr`/`mem_wdata` are held stable from BUS_WR/BUS_RD until the state leaves *_WAIT.
- rx_error:
  - In IDLE/GET_*: pulse `rx_ack`, abort to IDLE, no response.
  - Takes precedence over a simultaneous `rx_avail`.
- Bytes arriving during BUS_*/SEND*: not consumed and left pending. The host must wait for the response.
- Timeout:
  - Counter clears on entry to GET_* and on each accepted byte; it increments in GET_*.
  - On reaching `TIMEOUT_CYCLES`: IDLE, no response, no bus cycle.

## Timing
- Reset values: `rx_ack`=0, `tx_wr`=0, `tx_data`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0, `mem_rstrb`=0, `active`=0, state IDLE, counters 0.
- Reset mid-operation: all outputs return to reset values at the next edge. Any pending strobe is dropped and no response is sent.
- Write: last data byte accepted at edge E → `mem_wmask`=4'hF during cycle E+1. With `mem_wbusy`=0 throughout, `tx_wr` for 'K' at E+3 at the earliest.
- Read: last address byte accepted at E → `mem_rstrb`=1 during E+1. Data captured at the first edge after E+1 with `mem_rbusy`=0.
- Timeout fires on the edge where the counter equals `TIMEOUT_CYCLES`. A byte accepted on that same edge wins and clears the counter.

## Test plan
- Write: send 57 00 00 10 04 DE AD BE EF.
  - Expect one `mem_wmask`=F pulse, `mem_addr`=0x00001004, `mem_wdata`=0xDEADBEEF.
  - Expect tx 0x4B.
  - Expect exactly 9 `rx_ack` pulses.
- Read with wait states: send 52 00 00 20 03 with `mem_rbusy` held 3 cycles and `mem_rdata`=0x12345678.
  - Expect `mem_addr`=0x00002000.
  - Expect tx 12 34 56 78 in order, each `tx_wr` issued only when `tx_busy`=0.
- Unknown command: send 0x41 → tx 0x3F, no bus activity, `active`=0 afterwards.
- Timeout (`TIMEOUT_CYCLES`=100): send 57 00, then silence → IDLE after 100 cycles with no response. A following read frame completes normally.
- rx_error: assert `rx_error`=1 with `rx_avail`=1 mid-address → one `rx_ack`, IDLE, no tx, no bus cycle.
- Reset mid-operation: assert `reset` while in BUS_WR_WAIT with `mem_wbusy` held → next cycle all outputs at reset values and `active`=0.
